// File: rtl/prescaled_mod_counter.sv
// Modulo counter with a built-in prescaler: up, down or bounce over 0..limit-1,
// with synchronous load, out-of-range recovery and step/wrap strobes for chaining digits.
module prescaled_mod_counter #(
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 30
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PRE_WIDTH-1:0] period,
    input  logic [WIDTH-1:0]     limit,
    input  logic [1:0]           mode,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_value,
    output logic [WIDTH-1:0]     out,
    output logic                 step_pulse,
    output logic                 wrap_pulse,
    output logic                 dir
);

    // mode        | meaning
    // MODE_UP     | count up, wrap M->0
    // MODE_DOWN   | count down, wrap 0->M
    // MODE_BOUNCE | up to M, turn, down to 0, turn
    // MODE_HOLD   | prescaler and counter frozen
    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    mode_t                mode_sel;
    logic [PRE_WIDTH-1:0] pre_cnt;
    logic [WIDTH:0]       max_ext;
    logic [WIDTH-1:0]     max_val;
    logic                 run;
    logic                 step_ev;
    logic                 out_of_range;
    logic                 load_fits;
    logic [WIDTH-1:0]     nxt_out;
    logic                 nxt_dir;
    logic                 nxt_wrap;

    assign mode_sel = mode_t'(mode);

    // Adding all-ones in WIDTH+1 bits is limit-1; limit=0 selects the full range.
    assign max_ext = (limit == '0) ? {1'b0, {WIDTH{1'b1}}}
                                   : {1'b0, limit} + {(WIDTH+1){1'b1}};
    assign max_val = max_ext[WIDTH-1:0];

    assign out_of_range = ({1'b0, out} > max_ext);
    assign load_fits    = ({1'b0, load_value} <= max_ext);

    assign run     = enable && (mode_sel != MODE_HOLD);
    assign step_ev = run && ((period <= PRE_WIDTH'(1)) ||
                             (pre_cnt >= period - PRE_WIDTH'(1)));

    always_comb begin
        nxt_out  = out;
        nxt_dir  = dir;
        nxt_wrap = 1'b0;
        if (out_of_range) begin
            nxt_out  = '0;
            nxt_dir  = 1'b0;
            nxt_wrap = 1'b1;
        end else begin
            case (mode_sel)
                MODE_UP: begin
                    nxt_dir = 1'b0;
                    if (out == max_val) begin
                        nxt_out  = '0;
                        nxt_wrap = 1'b1;
                    end else begin
                        nxt_out = out + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    nxt_dir = 1'b1;
                    if (out == '0) begin
                        nxt_out  = max_val;
                        nxt_wrap = 1'b1;
                    end else begin
                        nxt_out = out - WIDTH'(1);
                    end
                end
                MODE_BOUNCE: begin
                    if (max_val == '0) begin
                        // single-value range: stay at 0, every step is a wrap
                        nxt_out  = '0;
                        nxt_wrap = 1'b1;
                    end else if (!dir) begin
                        if (out == max_val) begin
                            nxt_out  = out - WIDTH'(1);
                            nxt_dir  = 1'b1;
                            nxt_wrap = 1'b1;
                        end else begin
                            nxt_out = out + WIDTH'(1);
                        end
                    end else begin
                        if (out == '0) begin
                            nxt_out  = WIDTH'(1);
                            nxt_dir  = 1'b0;
                            nxt_wrap = 1'b1;
                        end else begin
                            nxt_out = out - WIDTH'(1);
                        end
                    end
                end
                MODE_HOLD: begin
                    nxt_out = out;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            out        <= '0;
            pre_cnt    <= '0;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            if (load) begin
                out     <= load_fits ? load_value : '0;
                pre_cnt <= '0;
                dir     <= 1'b0;
            end else if (run) begin
                if (step_ev) begin
                    pre_cnt    <= '0;
                    out        <= nxt_out;
                    dir        <= nxt_dir;
                    step_pulse <= 1'b1;
                    wrap_pulse <= nxt_wrap;
                end else begin
                    pre_cnt <= pre_cnt + PRE_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prescaled_mod_counter.sv
// Bench for prescaled_mod_counter: directed stimulus, a behavioural model checked
// every cycle, and hand-computed literal expectations at key points.
module tb_prescaled_mod_counter;

    localparam int W  = 8;
    localparam int PW = 30;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          enable;
    logic [PW-1:0] period;
    logic [W-1:0]  limit;
    logic [1:0]    mode;
    logic          load;
    logic [W-1:0]  load_value;
    logic [W-1:0]  out;
    logic          step_pulse;
    logic          wrap_pulse;
    logic          dir;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    prescaled_mod_counter #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .period     (period),
        .limit      (limit),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .out        (out),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse),
        .dir        (dir)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer arithmetic over the range 0..mx.
    int     m_out, m_dir, m_step, m_wrap;
    longint m_pre;

    function automatic void advance(input int mx, input int md);
        int p;
        int old_dir;
        if (m_out > mx) begin
            m_out = 0; m_dir = 0; m_wrap = 1;
        end else if (md == 0) begin
            m_wrap = (m_out == mx);
            m_out  = (m_out + 1) % (mx + 1);
            m_dir  = 0;
        end else if (md == 1) begin
            m_wrap = (m_out == 0);
            m_out  = (m_out + mx) % (mx + 1);
            m_dir  = 1;
        end else if (mx == 0) begin
            m_out = 0; m_wrap = 1;
        end else begin
            // bounce as a walk around a ring of positions 0..2mx
            old_dir = m_dir;
            p = m_dir ? (2 * mx - m_out) : m_out;
            p = (p == 2 * mx) ? 1 : p + 1;
            m_out  = (p <= mx) ? p : 2 * mx - p;
            m_dir  = (p > mx) ? 1 : 0;
            m_wrap = (m_dir != old_dir);
        end
    endfunction

    always @(posedge clk_in or posedge reset) begin
        int mx;
        if (reset) begin
            m_out = 0; m_dir = 0; m_pre = 0; m_step = 0; m_wrap = 0;
        end else begin
            mx = (limit == 0) ? (1 << W) - 1 : int'(limit) - 1;
            m_step = 0;
            m_wrap = 0;
            if (load) begin
                m_out = (int'(load_value) > mx) ? 0 : int'(load_value);
                m_pre = 0;
                m_dir = 0;
            end else if (enable && mode != 2'b11) begin
                if (m_pre + 1 >= longint'(period)) begin
                    m_pre  = 0;
                    m_step = 1;
                    advance(mx, int'(mode));
                end else begin
                    m_pre++;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_on) begin
            chk("model_out",  int'(out),        m_out);
            chk("model_dir",  int'(dir),        m_dir);
            chk("model_step", int'(step_pulse), m_step);
            chk("model_wrap", int'(wrap_pulse), m_wrap);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    int exp_bo[7] = '{1, 2, 3, 2, 1, 0, 1};
    int exp_bw[7] = '{0, 0, 0, 1, 0, 0, 1};
    int exp_bd[7] = '{0, 0, 0, 1, 1, 1, 0};

    initial begin
        reset = 1'b1; enable = 1'b0; period = 1; limit = 10; mode = 2'b00;
        load = 1'b0; load_value = 0;
        tick(2);
        chk("rst_out",  int'(out), 0);
        chk("rst_step", int'(step_pulse), 0);
        chk("rst_wrap", int'(wrap_pulse), 0);
        chk("rst_dir",  int'(dir), 0);
        chk_on = 1'b1;

        // up, period 4, limit 10
        reset = 1'b0; enable = 1'b1; period = 4;
        tick(4);
        chk("p4_first_out",  int'(out), 1);
        chk("p4_first_step", int'(step_pulse), 1);
        tick(35);
        chk("p4_out9",  int'(out), 9);
        chk("p4_nostep", int'(step_pulse), 0);
        tick(1);
        chk("p4_wrap_out", int'(out), 0);
        chk("p4_wrap",     int'(wrap_pulse), 1);

        // full 2^W range, every cycle
        period = 1; limit = 0; load = 1'b1; load_value = 0;
        tick(1);
        chk("load0_out",  int'(out), 0);
        chk("load0_step", int'(step_pulse), 0);
        load = 1'b0;
        tick(255);
        chk("full_255", int'(out), 255);
        tick(1);
        chk("full_wrap_out", int'(out), 0);
        chk("full_wrap",     int'(wrap_pulse), 1);
        mode = 2'b01;
        tick(1);
        chk("down_from0_out", int'(out), 255);
        chk("down_from0_wrap", int'(wrap_pulse), 1);
        chk("down_dir", int'(dir), 1);

        // bounce over limit 4
        limit = 4; mode = 2'b10; load = 1'b1; load_value = 0;
        tick(1);
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk("bounce_out",  int'(out), exp_bo[i]);
            chk("bounce_wrap", int'(wrap_pulse), exp_bw[i]);
            chk("bounce_dir",  int'(dir), exp_bd[i]);
        end
        limit = 1;
        tick(1);
        chk("lim1_oor_out",  int'(out), 0);
        chk("lim1_oor_wrap", int'(wrap_pulse), 1);
        tick(3);
        chk("lim1_hold_out",  int'(out), 0);
        chk("lim1_hold_wrap", int'(wrap_pulse), 1);

        // load on a step cycle, down, limit 10
        mode = 2'b01; limit = 10; load = 1'b1; load_value = 7;
        tick(1);
        chk("load7_out",  int'(out), 7);
        chk("load7_step", int'(step_pulse), 0);
        chk("load7_wrap", int'(wrap_pulse), 0);
        load = 1'b0;
        tick(1);
        chk("after_load7_out", int'(out), 6);
        chk("after_load7_step", int'(step_pulse), 1);

        // limit lowered below out, and an oversized load value
        mode = 2'b00; load = 1'b1; load_value = 8;
        tick(1);
        load = 1'b0; limit = 5;
        tick(1);
        chk("oor_out",  int'(out), 0);
        chk("oor_wrap", int'(wrap_pulse), 1);
        load = 1'b1; load_value = 9;
        tick(1);
        chk("load9_lim5_out", int'(out), 0);
        load = 1'b0;

        // period lowered below pre_cnt, freeze, hold, load while frozen
        limit = 10; period = 8; load = 1'b1; load_value = 2;
        tick(1);
        load = 1'b0;
        tick(5);
        period = 3;
        tick(1);
        chk("period_drop_out",  int'(out), 3);
        chk("period_drop_step", int'(step_pulse), 1);
        enable = 1'b0;
        tick(4);
        chk("frozen_out", int'(out), 3);
        load = 1'b1; load_value = 5;
        tick(1);
        chk("frozen_load", int'(out), 5);
        load = 1'b0; enable = 1'b1; mode = 2'b11;
        tick(3);
        chk("hold_out", int'(out), 5);
        mode = 2'b00;
        tick(7);

        // async reset between edges, down mode so dir is set
        period = 1; mode = 2'b01;
        tick(3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out",  int'(out), 0);
        chk("mid_rst_step", int'(step_pulse), 0);
        chk("mid_rst_wrap", int'(wrap_pulse), 0);
        chk("mid_rst_dir",  int'(dir), 0);
        @(negedge clk_in);
        reset = 1'b0; mode = 2'b00;
        tick(1);
        chk("resume_out", int'(out), 1);
        tick(4);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
